// File: rtl/strobe_pacer.sv
// Counts incoming strobes and re-issues them one per GAP cycles so a slow
// downstream cross-clock transfer never sees two strobes inside its round trip.
module strobe_pacer #(
    parameter int CW  = 8,
    parameter int GAP = 16
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_stb,
    input  logic          i_flush,
    input  logic          i_clr_overflow,
    output logic          o_stb,
    output logic [CW-1:0] o_pending,
    output logic          o_overflow,
    output logic          o_busy
);

    // state   | meaning
    // IDLE    | gap counter is zero, next event may be issued this edge
    // HOLDOFF | gap counter non-zero, counting down the spacing to the next issue
    typedef enum logic {
        IDLE    = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    localparam logic [CW-1:0] PEND_MAX   = {CW{1'b1}};
    localparam logic [15:0]   GAP_RELOAD = 16'(GAP - 1);

    state_t      state;
    logic [15:0] gap_cnt;
    logic        issue;
    logic        drop;

    assign issue  = (state == IDLE) && !i_flush && ((o_pending != '0) || i_stb);
    // A strobe is lost only when it cannot be absorbed by a same-cycle issue.
    assign drop   = i_stb && !i_flush && !issue && (o_pending == PEND_MAX);
    assign o_busy = (o_pending != '0) || (state == HOLDOFF);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            o_stb      <= 1'b0;
            o_pending  <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_stb <= issue;

            case (state)
                IDLE: begin
                    if (issue) begin
                        gap_cnt <= GAP_RELOAD;
                        state   <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    gap_cnt <= gap_cnt - 16'd1;
                    if (gap_cnt == 16'd1) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    gap_cnt <= '0;
                end
            endcase

            if (i_flush) begin
                o_pending <= '0;
            end else if (issue) begin
                if (!i_stb) begin
                    o_pending <= o_pending - 1'b1;
                end
            end else if (i_stb && (o_pending != PEND_MAX)) begin
                o_pending <= o_pending + 1'b1;
            end

            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_overflow) begin
                o_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_strobe_pacer.sv
// Bench for strobe_pacer: directed scenarios plus random traffic, all compared
// against a time-based reference model of the pacing rules.
module tb_strobe_pacer;

    localparam int GAP  = 16;
    localparam int CW   = 2;
    localparam int MAXP = (1 << CW) - 1;

    logic          clk;
    logic          reset_n;
    logic          stb;
    logic          flush;
    logic          clr_ovf;
    logic          o_stb;
    logic [CW-1:0] o_pending;
    logic          o_overflow;
    logic          o_busy;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    // Reference model state: backlog, sticky flag and the edge number of the
    // last issue; spacing is derived from edge arithmetic, not a counter.
    longint edge_n     = 0;
    longint m_last     = 0;
    bit     m_has_last = 0;
    int     m_pending  = 0;
    bit     m_ovf      = 0;
    bit     m_stb      = 0;
    bit     m_busy     = 0;

    strobe_pacer #(.CW(CW), .GAP(GAP)) dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_stb          (stb),
        .i_flush        (flush),
        .i_clr_overflow (clr_ovf),
        .o_stb          (o_stb),
        .o_pending      (o_pending),
        .o_overflow     (o_overflow),
        .o_busy         (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at edge %0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_edge(input bit s, input bit f, input bit c, input bit r);
        bit can_issue;
        bit issue;
        bit ovf_set;
        if (!r) begin
            m_pending  = 0;
            m_ovf      = 0;
            m_stb      = 0;
            m_has_last = 0;
        end else begin
            can_issue = !m_has_last || (edge_n >= m_last + GAP);
            issue     = can_issue && !f && (m_pending > 0 || s);
            ovf_set   = 0;
            if (f)
                m_pending = 0;
            else if (issue)
                m_pending = m_pending + int'(s) - 1;
            else if (s) begin
                if (m_pending == MAXP) ovf_set = 1;
                else m_pending++;
            end
            if (ovf_set) m_ovf = 1;
            else if (c) m_ovf = 0;
            m_stb = issue;
            if (issue) begin
                m_last     = edge_n;
                m_has_last = 1;
            end
        end
        // Holdoff occupies the GAP-1 cycles after an issue edge.
        m_busy = (m_pending != 0) || (m_has_last && edge_n <= m_last + GAP - 2);
    endtask

    task automatic step(input bit s, input bit f = 0, input bit c = 0, input bit r = 1);
        stb     = s;
        flush   = f;
        clr_ovf = c;
        reset_n = r;
        @(posedge clk);
        edge_n++;
        model_edge(s, f, c, r);
        #1;
        if (o_stb === 1'b1) pulses++;
        chk("o_stb", int'(o_stb), int'(m_stb));
        chk("o_pending", int'(o_pending), m_pending);
        chk("o_overflow", int'(o_overflow), int'(m_ovf));
        chk("o_busy", int'(o_busy), int'(m_busy));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    initial begin
        stb = 0; flush = 0; clr_ovf = 0; reset_n = 0;

        // Reset state
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("reset_pending", int'(o_pending), 0);
        chk("reset_busy", int'(o_busy), 0);
        idle(5);

        // 1: single strobe while idle
        pulses = 0;
        step(1);
        chk("t1_stb_next", int'(o_stb), 1);
        chk("t1_pending", int'(o_pending), 0);
        idle(40);
        chk("t1_pulses", pulses, 1);

        // 2: three back-to-back strobes
        pulses = 0;
        step(1); step(1); step(1);
        chk("t2_pending", int'(o_pending), 2);
        idle(60);
        chk("t2_pulses", pulses, 3);
        chk("t2_drained", int'(o_pending), 0);

        // 3: six strobes saturate a 2-bit backlog
        pulses = 0;
        for (int i = 0; i < 6; i++) step(1);
        chk("t3_ovf", int'(o_overflow), 1);
        chk("t3_sat", int'(o_pending), MAXP);
        idle(70);
        chk("t3_pulses", pulses, 4);
        step(0, 0, 1);
        chk("t3_clr", int'(o_overflow), 0);

        // 4: flush with strobe during holdoff
        step(0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) step(1);
        idle(3);
        step(1, 1);
        chk("t4_flushed", int'(o_pending), 0);
        idle(30);
        chk("t4_pulses", pulses, 1);
        chk("t4_busy_end", int'(o_busy), 0);

        // 5: strobe coincides with scheduled issue at max backlog
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1);
        idle(12);
        step(1);
        chk("t5_stb", int'(o_stb), 1);
        chk("t5_pending", int'(o_pending), MAXP);
        chk("t5_ovf", int'(o_overflow), 0);
        idle(60);

        // 6: reset mid-holdoff with backlog
        for (int i = 0; i < 3; i++) step(1);
        idle(3);
        step(0, 0, 0, 0);
        chk("t6_pending", int'(o_pending), 0);
        chk("t6_busy", int'(o_busy), 0);
        step(1);
        chk("t6_restart", int'(o_stb), 1);
        idle(20);

        // Random traffic, density varied in phases
        for (int i = 0; i < 3000; i++) begin
            int thr;
            case ((i / 250) % 4)
                0: thr = 5;
                1: thr = 25;
                2: thr = 50;
                default: thr = 90;
            endcase
            step($urandom_range(99) < thr,
                 $urandom_range(199) == 0,
                 $urandom_range(29) == 0,
                 $urandom_range(999) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
